dispatch: RTL and testbench

Dispatch scheduler between rename and the reservation stations. It accepts one renamed micro-op per cycle into a single holding slot and classifies it from its rsop and memory/CSR flags. It forwards the op to exactly one of five issue targets (ALU, branch, LSU, complex mul/div, CSR) once that target has room. CSR accesses are serialized: each waits until it is the ROB head, and no later op dispatches until the CSR unit reports completion.

---
 rtl/dispatch_pkg.sv | 32 +++
 rtl/dispatch_classify.sv | 30 +++
 rtl/dispatch.sv | 130 +++++++++++++
 tb/tb_dispatch.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_pkg
// Description : Shared types and rsop decode constants for the dispatch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package dispatch_pkg;

   typedef enum logic [2:0] {
      CLS_ALU = 3'd0,
      CLS_BR  = 3'd1,
      CLS_LSU = 3'd2,
      CLS_MUL = 3'd3,
      CLS_CSR = 3'd4
   } dispatch_cls_e;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } dispatch_state_e;

   localparam logic [4:0] RSOP_JALR     = 5'b10000;
   localparam logic [4:0] RSOP_GRP_MASK = 5'b11000;
   localparam logic [4:0] RSOP_GRP_MUL  = 5'b11000;
   localparam logic [4:0] RSOP_GRP_BR   = 5'b01000;

   function automatic logic rsop_in_grp(input logic [4:0] rsop, input logic [4:0] grp);
      return (rsop & RSOP_GRP_MASK) == grp;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dispatch_classify.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_classify
// Description : Combinational issue-target decode from rsop and op flags.
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_classify
   import dispatch_pkg::*;
(
   input  logic [4:0]    rsop,
   input  logic          uses_memory,
   input  logic          csr_access,
   output dispatch_cls_e cls
);

   always_comb begin
      cls = CLS_ALU;
      if (csr_access) begin
         cls = CLS_CSR;
      end else if (uses_memory) begin
         cls = CLS_LSU;
      end else if (rsop_in_grp(rsop, RSOP_GRP_MUL)) begin
         cls = CLS_MUL;
      end else if ((rsop == RSOP_JALR) || rsop_in_grp(rsop, RSOP_GRP_BR)) begin
         cls = CLS_BR;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dispatch.sv
`default_nettype none
// ============================================================================
// Module      : dispatch
// Description : Single-slot dispatch from rename to five issue targets with
//               CSR serialization against the ROB head.
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch
   import dispatch_pkg::*;
#(
   parameter int PAYLOAD_W = 96,
   parameter int ROBID_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rename_valid,
   input  logic [4:0]           rename_rsop,
   input  logic                 rename_uses_memory,
   input  logic                 rename_csr_access,
   input  logic [ROBID_W-1:0]   rename_robid,
   input  logic [PAYLOAD_W-1:0] rename_payload,
   output logic                 dispatch_stall,
   input  logic                 rob_flush,
   input  logic [ROBID_W-1:0]   rob_head_robid,
   input  logic                 alu_full,
   input  logic                 br_full,
   input  logic                 lsu_full,
   input  logic                 mul_full,
   input  logic                 csr_busy,
   output logic                 dispatch_alu_valid,
   output logic                 dispatch_br_valid,
   output logic                 dispatch_lsu_valid,
   output logic                 dispatch_mul_valid,
   output logic                 dispatch_csr_valid,
   output logic [4:0]           dispatch_rsop,
   output logic [ROBID_W-1:0]   dispatch_robid,
   output logic [PAYLOAD_W-1:0] dispatch_payload,
   input  logic                 csr_done
);

   dispatch_cls_e          w_in_cls;
   dispatch_state_e        r_state;
   dispatch_state_e        w_state_nxt;
   logic                   r_slot_valid;
   dispatch_cls_e          r_cls;
   logic [4:0]             r_rsop;
   logic [ROBID_W-1:0]     r_robid;
   logic [PAYLOAD_W-1:0]   r_payload;
   logic                   w_ready;
   logic                   w_fire;
   logic                   w_stall;
   logic                   w_load;

   // Classify on the way in so the registered class drives the strobes.
   dispatch_classify u_classify (
      .rsop        (rename_rsop),
      .uses_memory (rename_uses_memory),
      .csr_access  (rename_csr_access),
      .cls         (w_in_cls)
   );

   always_comb begin
      w_ready = 1'b0;
      case (r_cls)
         CLS_ALU: w_ready = ~alu_full;
         CLS_BR:  w_ready = ~br_full;
         CLS_LSU: w_ready = ~lsu_full;
         CLS_MUL: w_ready = ~mul_full;
         CLS_CSR: w_ready = (rob_head_robid == r_robid) & ~csr_busy;
         default: w_ready = 1'b0;
      endcase
   end

   // Flush wins over an issue that would otherwise happen this cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_fire      = r_slot_valid & (r_state == ST_RUN) & w_ready & ~rob_flush;
      w_stall     = (r_slot_valid & ~w_fire) | (r_state == ST_DRAIN);
      w_load      = rename_valid & ~w_stall & ~rob_flush;
      case (r_state)
         ST_RUN: begin
            if (w_fire && (r_cls == CLS_CSR)) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (csr_done || rob_flush) w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_slot_valid <= 1'b0;
         r_cls        <= CLS_ALU;
         r_rsop       <= '0;
         r_robid      <= '0;
         r_payload    <= '0;
      end else if (rob_flush) begin
         r_slot_valid <= 1'b0;
      end else if (w_load) begin
         r_slot_valid <= 1'b1;
         r_cls        <= w_in_cls;
         r_rsop       <= rename_rsop;
         r_robid      <= rename_robid;
         r_payload    <= rename_payload;
      end else if (w_fire) begin
         r_slot_valid <= 1'b0;
      end
   end

   assign dispatch_stall     = w_stall;
   assign dispatch_alu_valid = w_fire & (r_cls == CLS_ALU);
   assign dispatch_br_valid  = w_fire & (r_cls == CLS_BR);
   assign dispatch_lsu_valid = w_fire & (r_cls == CLS_LSU);
   assign dispatch_mul_valid = w_fire & (r_cls == CLS_MUL);
   assign dispatch_csr_valid = w_fire & (r_cls == CLS_CSR);
   assign dispatch_rsop      = r_rsop;
   assign dispatch_robid     = r_robid;
   assign dispatch_payload   = r_payload;

endmodule
`default_nettype wire

// File: tb/tb_dispatch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dispatch
// Description : Directed and randomized checks of dispatch against a slot model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch;

   localparam int PW = 96;
   localparam int RW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          rename_valid;
   logic [4:0]    rename_rsop;
   logic          rename_uses_memory;
   logic          rename_csr_access;
   logic [RW-1:0] rename_robid;
   logic [PW-1:0] rename_payload;
   logic          dispatch_stall;
   logic          rob_flush;
   logic [RW-1:0] rob_head_robid;
   logic          alu_full, br_full, lsu_full, mul_full, csr_busy;
   logic          dispatch_alu_valid, dispatch_br_valid, dispatch_lsu_valid;
   logic          dispatch_mul_valid, dispatch_csr_valid;
   logic [4:0]    dispatch_rsop;
   logic [RW-1:0] dispatch_robid;
   logic [PW-1:0] dispatch_payload;
   logic          csr_done;
   logic [4:0]    strobes;

   always #5 clk = ~clk;

   dispatch #(.PAYLOAD_W(PW), .ROBID_W(RW)) dut (
      .clk(clk), .rst(rst),
      .rename_valid(rename_valid), .rename_rsop(rename_rsop),
      .rename_uses_memory(rename_uses_memory), .rename_csr_access(rename_csr_access),
      .rename_robid(rename_robid), .rename_payload(rename_payload),
      .dispatch_stall(dispatch_stall), .rob_flush(rob_flush),
      .rob_head_robid(rob_head_robid),
      .alu_full(alu_full), .br_full(br_full), .lsu_full(lsu_full),
      .mul_full(mul_full), .csr_busy(csr_busy),
      .dispatch_alu_valid(dispatch_alu_valid), .dispatch_br_valid(dispatch_br_valid),
      .dispatch_lsu_valid(dispatch_lsu_valid), .dispatch_mul_valid(dispatch_mul_valid),
      .dispatch_csr_valid(dispatch_csr_valid),
      .dispatch_rsop(dispatch_rsop), .dispatch_robid(dispatch_robid),
      .dispatch_payload(dispatch_payload), .csr_done(csr_done)
   );

   // Strobe vector order: {alu, br, lsu, mul, csr}
   assign strobes = {dispatch_alu_valid, dispatch_br_valid, dispatch_lsu_valid,
                     dispatch_mul_valid, dispatch_csr_valid};

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one held op plus a "waiting for CSR completion" flag.
   // Class codes 0..4 = ALU, BR, LSU, MUL, CSR.
   bit            m_v;
   int            m_cls;
   logic [4:0]    m_rsop;
   logic [RW-1:0] m_robid;
   logic [PW-1:0] m_payload;
   bit            m_drain;

   function automatic int model_cls(input logic [4:0] rsop, input logic mem, input logic csr);
      if (csr) return 4;
      if (mem) return 2;
      if (rsop[4:3] == 2'b11) return 3;
      if (rsop == 5'b10000 || rsop[4:3] == 2'b01) return 1;
      return 0;
   endfunction

   function automatic bit m_fire();
      bit room;
      if (!m_v || m_drain || rob_flush) return 1'b0;
      case (m_cls)
         0: room = !alu_full;
         1: room = !br_full;
         2: room = !lsu_full;
         3: room = !mul_full;
         default: room = (rob_head_robid == m_robid) && !csr_busy;
      endcase
      return room;
   endfunction

   function automatic bit m_stall();
      return (m_v && !m_fire()) || m_drain;
   endfunction

   task automatic model_check();
      logic [4:0] exp_s;
      exp_s = m_fire() ? (5'b10000 >> m_cls) : 5'b00000;
      chk("model_strobes", strobes, exp_s);
      chk("model_stall", dispatch_stall, m_stall());
      if (m_fire()) begin
         chk("model_robid", dispatch_robid, m_robid);
         chk("model_rsop", dispatch_rsop, m_rsop);
         chk("model_payload", dispatch_payload, m_payload);
      end
   endtask

   task automatic model_step();
      bit f, s;
      if (rst || rob_flush) begin
         m_v = 0;
         m_drain = 0;
      end else begin
         f = m_fire();
         s = m_stall();
         if (m_drain && csr_done) m_drain = 0;
         else if (f && m_cls == 4) m_drain = 1;
         if (f) m_v = 0;
         if (rename_valid && !s) begin
            m_v       = 1;
            m_cls     = model_cls(rename_rsop, rename_uses_memory, rename_csr_access);
            m_rsop    = rename_rsop;
            m_robid   = rename_robid;
            m_payload = rename_payload;
         end
      end
   endtask

   task automatic settle();
      #1;
      model_check();
   endtask

   task automatic advance();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic op(input logic v, input logic [4:0] rs, input logic mem, input logic csr,
                     input logic [RW-1:0] id, input logic [PW-1:0] pl);
      rename_valid       = v;
      rename_rsop        = rs;
      rename_uses_memory = mem;
      rename_csr_access  = csr;
      rename_robid       = id;
      rename_payload     = pl;
   endtask

   task automatic idle();
      op(1'b0, 5'b0, 1'b0, 1'b0, '0, '0);
   endtask

   logic [4:0] cls_rsop [4] = '{5'b11010, 5'b10000, 5'b01011, 5'b01010};
   logic       cls_mem  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   logic [4:0] cls_exp  [4] = '{5'b00010, 5'b01000, 5'b01000, 5'b00100};

   initial begin
      rst = 1'b1;
      idle();
      rob_flush = 0; rob_head_robid = '0; csr_done = 0;
      alu_full = 0; br_full = 0; lsu_full = 0; mul_full = 0; csr_busy = 0;
      m_v = 0; m_drain = 0; m_cls = 0; m_rsop = '0; m_robid = '0; m_payload = '0;
      @(negedge clk);
      @(negedge clk);
      settle();
      chk("reset_stall", dispatch_stall, 1'b0);
      chk("reset_strobes", strobes, 5'b0);
      chk("reset_robid", dispatch_robid, 8'h00);
      chk("reset_payload", dispatch_payload, 96'h0);
      rst = 1'b0;
      advance();

      // Back-to-back ALU burst
      for (int k = 0; k < 9; k++) begin
         if (k < 8) op(1'b1, 5'b00000, 1'b0, 1'b0, RW'(k), PW'(k * 3 + 1));
         else idle();
         settle();
         chk("burst_stall", dispatch_stall, 1'b0);
         if (k > 0) begin
            chk("burst_alu", dispatch_alu_valid, 1'b1);
            chk("burst_robid", dispatch_robid, RW'(k - 1));
         end
         advance();
      end

      // LSU blocked by lsu_full for three cycles
      op(1'b1, 5'b00000, 1'b1, 1'b0, 8'd20, 96'h20);
      settle();
      advance();
      op(1'b1, 5'b00000, 1'b0, 1'b0, 8'd21, 96'h21);
      lsu_full = 1;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("lsu_full_stall", dispatch_stall, 1'b1);
         chk("lsu_full_strobe", dispatch_lsu_valid, 1'b0);
         advance();
      end
      lsu_full = 0;
      settle();
      chk("lsu_issue", dispatch_lsu_valid, 1'b1);
      chk("lsu_robid", dispatch_robid, 8'd20);
      chk("lsu_stall", dispatch_stall, 1'b0);
      advance();
      idle();
      settle();
      chk("after_lsu_alu", dispatch_alu_valid, 1'b1);
      chk("after_lsu_robid", dispatch_robid, 8'd21);
      advance();

      // CSR waits for the ROB head, then serializes the next op
      rob_head_robid = 8'h83;
      op(1'b1, 5'b00000, 1'b0, 1'b1, 8'h85, 96'h85);
      settle();
      advance();
      op(1'b1, 5'b00000, 1'b0, 1'b0, 8'h86, 96'h86);
      for (int k = 0; k < 2; k++) begin
         settle();
         chk("csr_wait_strobe", dispatch_csr_valid, 1'b0);
         chk("csr_wait_stall", dispatch_stall, 1'b1);
         advance();
      end
      rob_head_robid = 8'h85;
      settle();
      chk("csr_issue", dispatch_csr_valid, 1'b1);
      chk("csr_robid", dispatch_robid, 8'h85);
      chk("csr_issue_stall", dispatch_stall, 1'b0);
      advance();
      idle();
      for (int k = 0; k < 2; k++) begin
         settle();
         chk("drain_stall", dispatch_stall, 1'b1);
         chk("drain_alu", dispatch_alu_valid, 1'b0);
         advance();
      end
      csr_done = 1;
      settle();
      chk("done_cycle_alu", dispatch_alu_valid, 1'b0);
      advance();
      csr_done = 0;
      settle();
      chk("post_csr_alu", dispatch_alu_valid, 1'b1);
      chk("post_csr_robid", dispatch_robid, 8'h86);
      advance();
      rob_head_robid = '0;

      // Class decode
      for (int k = 0; k < 4; k++) begin
         op(1'b1, cls_rsop[k], cls_mem[k], 1'b0, RW'(k + 8'h30), PW'(k));
         settle();
         advance();
         idle();
         settle();
         chk("class_strobe", strobes, cls_exp[k]);
         advance();
      end

      // Flush coincident with a ready slot and an incoming op
      op(1'b1, 5'b00000, 1'b0, 1'b0, 8'd40, 96'h40);
      settle();
      advance();
      op(1'b1, 5'b00000, 1'b0, 1'b0, 8'd41, 96'h41);
      rob_flush = 1;
      settle();
      chk("flush_strobes", strobes, 5'b0);
      advance();
      rob_flush = 0;
      idle();
      settle();
      chk("flush_empty_strobes", strobes, 5'b0);
      chk("flush_empty_stall", dispatch_stall, 1'b0);
      advance();

      // Flush while draining a CSR
      rob_head_robid = 8'd50;
      op(1'b1, 5'b00000, 1'b0, 1'b1, 8'd50, 96'h50);
      settle();
      advance();
      idle();
      settle();
      chk("flush_csr_issue", dispatch_csr_valid, 1'b1);
      advance();
      op(1'b1, 5'b00000, 1'b0, 1'b0, 8'd51, 96'h51);
      rob_flush = 1;
      settle();
      chk("flush_drain_stall", dispatch_stall, 1'b1);
      advance();
      rob_flush = 0;
      settle();
      chk("post_flush_accept", dispatch_stall, 1'b0);
      advance();
      idle();
      settle();
      chk("post_flush_alu", dispatch_alu_valid, 1'b1);
      chk("post_flush_robid", dispatch_robid, 8'd51);
      advance();

      // Asynchronous reset mid-drain with a full slot
      rob_head_robid = 8'd60;
      op(1'b1, 5'b00000, 1'b0, 1'b1, 8'd60, 96'h60);
      settle();
      advance();
      op(1'b1, 5'b00000, 1'b0, 1'b0, 8'd61, 96'h61);
      settle();
      chk("areset_csr_issue", dispatch_csr_valid, 1'b1);
      advance();
      idle();
      settle();
      chk("areset_pre_stall", dispatch_stall, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("areset_stall", dispatch_stall, 1'b0);
      chk("areset_strobes", strobes, 5'b0);
      chk("areset_robid", dispatch_robid, 8'h00);
      chk("areset_payload", dispatch_payload, 96'h0);
      m_v = 0;
      m_drain = 0;
      advance();
      rst = 1'b0;
      rob_head_robid = '0;
      settle();
      advance();

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         op($urandom_range(0, 1) == 1, 5'($urandom), $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0, RW'($urandom), {$urandom, $urandom, $urandom});
         rob_flush      = $urandom_range(0, 29) == 0;
         alu_full       = $urandom_range(0, 2) == 0;
         br_full        = $urandom_range(0, 2) == 0;
         lsu_full       = $urandom_range(0, 2) == 0;
         mul_full       = $urandom_range(0, 2) == 0;
         csr_busy       = $urandom_range(0, 2) == 0;
         csr_done       = $urandom_range(0, 4) == 0;
         rob_head_robid = ($urandom_range(0, 1) == 1 && m_v) ? m_robid : RW'($urandom);
         settle();
         advance();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
